// File: rtl/fp_operand_normalizer.sv
// Converts a pair of signed 32-bit integers into IEEE-754 singles, one operand at a time.
// Optional build macro FP_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncate.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// LOAD  | take sign and magnitude of the selected operand
// NORM  | left-shift magnitude until bit 31 is set
// ROUND | extract mantissa, apply optional rounding
// PACK  | assemble result, store to A or B slot
// OUT   | present result pair until downstream accepts
module fp_operand_normalizer #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_a,
  input  logic [31:0] int_b,
  input  logic        op_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] operand_normalized_ieee_a,
  output logic [31:0] operand_normalized_ieee_b,
  output logic        op
);

  typedef enum logic [2:0] {IDLE, LOAD, NORM, ROUND, PACK, OUT} state_t;

  // 158 = 127 + 31: exponent of a magnitude whose leading one sits in bit 31
  localparam logic [7:0] EXP_TOP = 8'd158;
  localparam logic [7:0] STEP    = 8'(SHIFT_STEP);

  state_t      state_q;
  logic        sel_q;
  logic        sign_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] mag_q;
  logic [31:0] res_a_q;
  logic [31:0] res_b_q;
  logic [7:0]  exp_q;
  logic [22:0] mant_q;

  logic [31:0] src_d;
  logic [31:0] mag_d;
  logic        step_zero_d;
  logic        round_up_d;
  logic [23:0] mant_d;
  logic [31:0] result_d;

  assign src_d       = sel_q ? b_q : a_q;
  // Negating 0x80000000 wraps back to itself, which is the correct unsigned magnitude
  assign mag_d       = src_d[31] ? (~src_d + 32'd1) : src_d;
  assign step_zero_d = (mag_q[31 -: SHIFT_STEP] == '0);
  assign mant_d      = {1'b0, mag_q[30:8]} + {23'd0, round_up_d};
  assign result_d    = {sign_q, exp_q, mant_q};

`ifdef FP_ROUND_NEAREST_EN
  logic guard_d;
  logic sticky_d;
  assign guard_d    = mag_q[7];
  assign sticky_d   = |mag_q[6:0];
  assign round_up_d = guard_d & (sticky_d | mag_q[8]);
`else
  assign round_up_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mag_q       <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      exp_q       <= '0;
      mant_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= int_a;
            b_q        <= int_b;
            op_q       <= op_in;
            sel_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          mag_q  <= mag_d;
          mant_q <= '0;
          if (mag_d == '0) begin
            sign_q  <= 1'b0;
            exp_q   <= '0;
            state_q <= PACK;
          end else begin
            sign_q  <= src_d[31];
            exp_q   <= EXP_TOP;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (mag_q[31]) begin
            state_q <= ROUND;
          end else if (step_zero_d) begin
            mag_q <= mag_q << SHIFT_STEP;
            exp_q <= exp_q - STEP;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          if (mant_d[23]) begin
            mant_q <= '0;
            exp_q  <= exp_q + 8'd1;
          end else begin
            mant_q <= mant_d[22:0];
          end
          state_q <= PACK;
        end
        PACK: begin
          if (!sel_q) begin
            res_a_q <= result_d;
            sel_q   <= 1'b1;
            state_q <= LOAD;
          end else begin
            res_b_q     <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready                  = in_ready_q;
  assign out_valid                 = out_valid_q;
  assign operand_normalized_ieee_a = res_a_q;
  assign operand_normalized_ieee_b = res_b_q;
  assign op                        = op_q;

endmodule

// File: doc/fp_operand_normalizer.md
FP_OPERAND_NORMALIZER -- requirements
Module: fp_operand_normalizer

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 1, max left-shift bits per NORM cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have clk input 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n input 1: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have in_valid input 1: int_a/int_b/op_in valid.
REQ-005 SHALL have in_ready output 1: block can accept an operand pair.
REQ-006 SHALL have int_a input 32: signed two's-complement operand A.
REQ-007 SHALL have int_b input 32: signed two's-complement operand B.
REQ-008 SHALL have op_in input 1: add/subtract selector, passed through unchanged.
REQ-009 SHALL have out_valid output 1: result pair valid.
REQ-010 SHALL have out_ready input 1: downstream adder consumes pair.
REQ-011 SHALL have operand_normalized_ieee_a output 32: IEEE-754 single of int_a, normalized.
REQ-012 SHALL have operand_normalized_ieee_b output 32: IEEE-754 single of int_b, normalized.
REQ-013 SHALL have op output 1: registered op_in of the accepted pair.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, NORM, ROUND, PACK, OUT; internal sel bit (0=A, 1=B).
REQ-015 IDLE: in_ready=1; on in_valid&in_ready, capture int_a, int_b, op_in, set sel=0, go LOAD; in_ready=0 in every other state.
REQ-016 LOAD: sign=x[31]; mag=|x| as 32-bit unsigned (0x80000000 gives mag 0x80000000); exp=158; if mag==0, go PACK with result 0x00000000, else go NORM.
REQ-017 NORM: if mag[31]==1, go ROUND with no shift; else if the top SHIFT_STEP bits are all zero, shift mag left SHIFT_STEP and subtract SHIFT_STEP from exp; else shift left 1 and subtract 1.
REQ-018 ROUND: mant=mag[30:8], guard=mag[7], sticky=|mag[6:0]; rounding per REQ-026; if the increment carries out of mant, set mant=0 and exp=exp+1.
REQ-019 PACK: result={sign,exp[7:0],mant}; store to A register if sel==0, then set sel=1 and go LOAD; store to B register if sel==1, then go OUT.
REQ-020 OUT: out_valid=1; outputs and op held stable while out_ready==0; on out_ready==1, go IDLE and drop out_valid next cycle.
REQ-021 Per-operand cycles SHALL be 4+k (k = NORM shift cycles), or 2 for zero.
REQ-022 out_valid SHALL rise exactly (cycles_A + cycles_B) rising edges after the accepting edge.
REQ-023 Exponent SHALL stay in 127..158; no overflow, underflow, NaN, inf or denormal is ever produced.
REQ-024 in_valid while busy SHALL be ignored, with no capture and no state change.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, sel=0, in_ready=1 after release, out_valid=0, op=0, and both operand outputs 0x00000000; reset mid-conversion SHALL discard the pair.

Configuration
REQ-026 Macro FP_ROUND_NEAREST_EN defined: round-to-nearest-even, incrementing when guard & (sticky | mant[0]); undefined: truncate, with no increment and ROUND still one cycle so latency is unchanged.

Verification
REQ-027 SHIFT_STEP=1, int_a=1, int_b=-1, op_in=0 -> a=0x3F800000, b=0xBF800000, op=0; out_valid rises at edge 70 after accept.
REQ-028 int_a=0, int_b=0x80000000, op_in=1 -> a=0x00000000, b=0xCF000000, op=1; out_valid rises at edge 6.
REQ-029 int_a=0x7FFFFFFF, int_b=0x01000003 -> with macro: a=0x4F000000, b=0x4B800002; without: a=0x4EFFFFFF, b=0x4B800001.
REQ-030 SHIFT_STEP=4, int_a=1, int_b=1 -> both 0x3F800000; NORM takes 7x4 plus 3x1 shifts, so k=10 each and out_valid rises at edge 28.
REQ-031 Backpressure: out_ready=0 for 5 cycles in OUT while in_valid=1 with new data -> out_valid, outputs and op unchanged; in_ready=0; the new data is not captured.
REQ-032 rst_n pulsed low during NORM -> outputs 0x00000000 and out_valid=0 immediately; in_ready=1 the cycle after release; the next pair converts correctly.
